// File: rtl/if_id_fifo.sv
// IF/ID decoupling buffer: a small circular FIFO between fetch and decode.
// Fetch pushes {inst, addr} pairs. Decode sees the head entry, or a NOP when the
// buffer is empty. A flush drops every buffered entry. A stall holds the head entry.
// DEPTH must be a power of two from 2 to 16. Because of that, the pointers wrap
// naturally at their own width, and no separate wrap flag is needed.
module if_id_fifo #(
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INST_W-1:0]        inst_i,
    input  logic [ADDR_W-1:0]        inst_addr_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     hold_en,
    input  logic                     flush_i,
    output logic [INST_W-1:0]        inst_o,
    output logic [ADDR_W-1:0]        inst_addr_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned        PTR_W    = $clog2(DEPTH);
    localparam int unsigned        CNT_W    = PTR_W + 1;
    localparam int unsigned        ENT_W    = INST_W + ADDR_W;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Storage is deliberately left unreset. valid_o masks stale contents.
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] head;

    logic push;
    logic pop;

    // Handshake status depends only on occupancy. A pop does not free a slot
    // until the next cycle.
    always_comb begin
        ready_o = (cnt_q != FULL_CNT);
        valid_o = (cnt_q != '0);
        push    = valid_i && ready_o && !flush_i;
        pop     = valid_o && !hold_en && !flush_i;
    end

    // Next-state for the pointers and the occupancy counter. A flush overrides any push or pop.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = wp_q + PTR_W'(1);
            if (pop)  rp_d = rp_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and counter registers, with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage write. The array has no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {inst_i, inst_addr_i};
    end

    // Head presentation. When the buffer is empty, decode sees a NOP at address 0.
    always_comb begin
        head        = mem_q[rp_q];
        inst_o      = NOP_INST;
        inst_addr_o = '0;
        if (valid_o) begin
            inst_o      = head[ENT_W-1:ADDR_W];
            inst_addr_o = head[ADDR_W-1:0];
        end
        count_o = cnt_q;
    end

endmodule

// File: doc/if_id_fifo.md
IF_ID_FIFO -- requirements
Module: if_id_fifo

Interface
REQ-001 SHALL have parameter INST_W, default 32, instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, instruction address width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; legal values are powers of two from 2 to 16.
REQ-004 SHALL have parameter NOP_INST, default 32'h00000013, the instruction presented when the buffer is empty.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous reset, active-low.
REQ-007 SHALL have port inst_i, input, INST_W bits, fetched instruction.
REQ-008 SHALL have port inst_addr_i, input, ADDR_W bits, fetched instruction address.
REQ-009 SHALL have port valid_i, input, 1 bit, fetch offers an entry.
REQ-010 SHALL have port ready_o, output, 1 bit, buffer accepts an entry this cycle.
REQ-011 SHALL have port hold_en, input, 1 bit, decode stalled; no entry is consumed.
REQ-012 SHALL have port flush_i, input, 1 bit, discard all buffered entries (branch or jump redirect).
REQ-013 SHALL have port inst_o, output, INST_W bits, head instruction to decode.
REQ-014 SHALL have port inst_addr_o, output, ADDR_W bits, head address to decode.
REQ-015 SHALL have port valid_o, output, 1 bit, head entry is valid.
REQ-016 SHALL have port count_o, output, $clog2(DEPTH)+1 bits, number of occupied entries.

Function
REQ-017 SHALL store entries in a circular buffer with write pointer wp, read pointer rp (each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0) and an occupancy counter cnt.
REQ-018 SHALL drive ready_o = (cnt != DEPTH), independent of hold_en and flush_i.
REQ-019 SHALL push, when valid_i && ready_o && !flush_i: write {inst_i, inst_addr_i} at wp and increment wp.
REQ-020 SHALL drive valid_o = (cnt != 0).
REQ-021 SHALL pop, when valid_o && !hold_en && !flush_i: increment rp.
REQ-022 SHALL update cnt by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-023 SHALL drive inst_o and inst_addr_o from entry rp when valid_o=1, and NOP_INST and 0 when valid_o=0.
REQ-024 SHALL give a pushed entry a latency of exactly one cycle to the outputs when the buffer is empty; there is no combinational path from inst_i to inst_o.
REQ-025 SHALL give flush_i priority: on a flush edge wp, rp and cnt become 0 and any same-cycle push or pop is dropped; the next cycle shows valid_o=0 and inst_o=NOP_INST.
REQ-026 SHALL, when full (ready_o=0), refuse the push even if a pop occurs the same cycle; the freed slot is visible on ready_o the following cycle.
REQ-027 SHALL, when empty, not pop and not underflow rp or cnt, whatever hold_en is.
REQ-028 SHALL keep outputs and storage unchanged while hold_en=1 and no push occurs.
REQ-029 SHALL drive count_o = cnt, which SHALL never exceed DEPTH.
REQ-030 SHALL produce correct pointer wrap for every legal DEPTH, with no separate wrap flag.

Reset
REQ-031 SHALL, while rst=0, asynchronously force wp=0, rp=0 and cnt=0, giving valid_o=0, ready_o=1, count_o=0, inst_o=NOP_INST and inst_addr_o=0.
REQ-032 SHALL leave storage array contents unreset; outputs are masked by valid_o.
REQ-033 SHALL discard all entries if reset is asserted mid-operation, and SHALL accept the first push on the first rising edge after rst rises.

Verification
REQ-034 Reset: rst=0 with 3 entries held -> immediately valid_o=0, count_o=0, inst_o=32'h00000013, ready_o=1.
REQ-035 Latency: empty buffer, push {32'h00500093, 32'h00000010} with hold_en=0 -> next cycle valid_o=1, inst_o=32'h00500093, inst_addr_o=32'h10; one cycle later valid_o=0.
REQ-036 Fill/stall: DEPTH=4, hold_en=1, push addresses 0x0,0x4,0x8,0xC, offer 0x10 -> ready_o=0 after the 4th push, count_o=4, 0x10 not accepted; release hold_en -> pops in order 0x0,0x4,0x8,0xC.
REQ-037 Wrap: stream 10 entries with hold_en toggling every other cycle -> addresses emerge in order 0x0..0x24 with none lost or duplicated, and count_o stays at or below 4.
REQ-038 Flush: 3 entries held, flush_i=1 together with valid_i=1 -> next cycle count_o=0, valid_o=0; the same-cycle entry is absent.
REQ-039 Full simultaneous: full buffer, hold_en=0, valid_i=1 -> pop occurs and push is refused (count_o=3); the next cycle ready_o=1 and the push is accepted.
